// File: rtl/data_mem_interconnect.sv
// Registered, handshaked data-side bus: CPU load/store port and NREG memory regions.
// Define DBG_PORT_EN to add the arbitrated debug read port with bounded starvation.
module data_mem_interconnect #(
  parameter int unsigned      ADDR_W       = 20,
  parameter int unsigned      DATA_W       = 32,
  parameter int unsigned      DBG_W        = 16,
  parameter int unsigned      NREG         = 3,
  parameter logic [NREG-1:0]  RO_MASK      = 3'b010,
  parameter int unsigned      READ_LAT     = 1,
  parameter int unsigned      DBG_MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_ready,
  output logic                     cpu_err,
  input  logic                     dbg_req,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DBG_W-1:0]         dbg_rdata,
  output logic                     dbg_valid,
  output logic [NREG-1:0]          mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-(NREG > 1 ? $clog2(NREG) : 1)-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [NREG*DATA_W-1:0]   mem_rdata
);
  localparam int unsigned SEL_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned OFS_W = ADDR_W - SEL_W;
  localparam int unsigned LAT_W = 3;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  state_t              state;
  logic [LAT_W-1:0]    lat_cnt;
  logic [SEL_W-1:0]    cur_reg;
  logic                cpu_gnt;
  logic                dbg_gnt;
  logic                gnt;
  logic [ADDR_W-1:0]   gnt_addr;
  logic [SEL_W-1:0]    gnt_reg;
  logic [NREG-1:0]     gnt_onehot;
  logic                gnt_mapped;
  logic                gnt_ro;
  logic                gnt_we;
  logic                gnt_fault;
  logic                gnt_access;
  logic [DATA_W-1:0]   rd_word;

`ifdef DBG_PORT_EN
  localparam int unsigned WC_W = (DBG_MAX_WAIT > 0) ? $clog2(DBG_MAX_WAIT + 1) : 1;
  logic [WC_W-1:0]     wait_cnt;
  logic                wait_full;
  logic                cur_dbg;

  // Debug takes the bus when the CPU is quiet or has starved it long enough
  assign wait_full = (wait_cnt == WC_W'(DBG_MAX_WAIT));
  assign dbg_gnt   = (state == IDLE) && dbg_req && (!cpu_req || wait_full);
  assign gnt_addr  = dbg_gnt ? dbg_addr : cpu_addr;
`else
  logic unused_dbg;
  assign unused_dbg = ^{dbg_req, dbg_addr, DBG_MAX_WAIT};
  assign dbg_gnt    = 1'b0;
  assign gnt_addr   = cpu_addr;
  assign dbg_rdata  = '0;
  assign dbg_valid  = 1'b0;
`endif

  assign cpu_gnt = (state == IDLE) && cpu_req && !dbg_gnt;
  assign gnt     = cpu_gnt || dbg_gnt;
  assign gnt_we  = cpu_gnt && cpu_we;

  // Region decode; indices at or above NREG stay unmapped
  always_comb begin
    gnt_reg    = gnt_addr[ADDR_W-1 -: SEL_W];
    gnt_onehot = '0;
    gnt_mapped = 1'b0;
    gnt_ro     = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (gnt_reg == SEL_W'(i)) begin
        gnt_onehot[i] = 1'b1;
        gnt_mapped    = 1'b1;
        gnt_ro        = RO_MASK[i];
      end
    end
  end

  assign gnt_fault  = !gnt_mapped || (gnt_we && gnt_ro);
  // Gated by rst so the memory strobes drop the moment reset asserts
  assign gnt_access = gnt && rst && !gnt_fault;
  assign mem_en     = gnt_access ? gnt_onehot : '0;
  assign mem_we     = gnt_access && gnt_we;
  assign mem_addr   = gnt_addr[OFS_W-1:0];
  assign mem_wdata  = cpu_wdata;

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (cur_reg == SEL_W'(i)) rd_word = mem_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      cur_reg   <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
`ifdef DBG_PORT_EN
      wait_cnt  <= '0;
      cur_dbg   <= 1'b0;
      dbg_rdata <= '0;
      dbg_valid <= 1'b0;
`endif
    end else begin
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
`ifdef DBG_PORT_EN
      dbg_valid <= 1'b0;
      if (!dbg_req || dbg_gnt) wait_cnt <= '0;
      else if (cpu_gnt && !wait_full) wait_cnt <= wait_cnt + 1'b1;
`endif
      case (state)
        IDLE: begin
          if (gnt) begin
            cur_reg <= gnt_reg;
`ifdef DBG_PORT_EN
            cur_dbg <= dbg_gnt;
`endif
            if (gnt_fault) begin
              state <= RESP;
              if (cpu_gnt) begin
                cpu_ready <= 1'b1;
                cpu_err   <= 1'b1;
                if (!cpu_we) cpu_rdata <= '0;
              end
`ifdef DBG_PORT_EN
              else begin
                dbg_valid <= 1'b1;
                dbg_rdata <= '0;
              end
`endif
            end else if (gnt_we) begin
              state     <= RESP;
              cpu_ready <= 1'b1;
            end else begin
              state   <= RD_WAIT;
              lat_cnt <= LAT_W'(READ_LAT);
            end
          end
        end
        RD_WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LAT_W'(1)) begin
            state <= RESP;
`ifdef DBG_PORT_EN
            if (cur_dbg) begin
              dbg_valid <= 1'b1;
              dbg_rdata <= rd_word[DBG_W-1:0];
            end else
`endif
            begin
              cpu_ready <= 1'b1;
              cpu_rdata <= rd_word;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_interconnect.sv
// Scoreboard bench for data_mem_interconnect: reference memory model, response queues
// and a negedge monitor; debug-port checks follow DBG_PORT_EN.
module tb_data_mem_interconnect;
  localparam int unsigned ADDR_W       = 20;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned DBG_W        = 16;
  localparam int unsigned NREG         = 3;
  localparam int unsigned READ_LAT     = 3;
  localparam int unsigned DBG_MAX_WAIT = 8;
  localparam int unsigned DEPTH        = 64;
  localparam logic [NREG-1:0] RO       = 3'b010;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   cpu_req = 1'b0;
  logic                   cpu_we = 1'b0;
  logic [ADDR_W-1:0]      cpu_addr = '0;
  logic [DATA_W-1:0]      cpu_wdata = '0;
  logic [DATA_W-1:0]      cpu_rdata;
  logic                   cpu_ready;
  logic                   cpu_err;
  logic                   dbg_req = 1'b0;
  logic [ADDR_W-1:0]      dbg_addr = '0;
  logic [DBG_W-1:0]       dbg_rdata;
  logic                   dbg_valid;
  logic [NREG-1:0]        mem_en;
  logic                   mem_we;
  logic [ADDR_W-3:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [NREG*DATA_W-1:0] mem_rdata;

  data_mem_interconnect #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DBG_W(DBG_W), .NREG(NREG), .RO_MASK(RO),
    .READ_LAT(READ_LAT), .DBG_MAX_WAIT(DBG_MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .dbg_valid(dbg_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory regions as the bus sees them: read data valid only in the READ_LAT-th cycle
  logic [DATA_W-1:0] dev_mem  [NREG][DEPTH];
  logic [DATA_W-1:0] ref_mem  [NREG][DEPTH];
  int                pend_cnt [NREG];
  logic [DATA_W-1:0] pend_data[NREG];

  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (mem_en[i] && mem_we) dev_mem[i][mem_addr[5:0]] <= mem_wdata;
      if (mem_en[i] && !mem_we) begin
        pend_cnt[i]  <= READ_LAT;
        pend_data[i] <= dev_mem[i][mem_addr[5:0]];
      end else if (pend_cnt[i] > 0) begin
        pend_cnt[i] <= pend_cnt[i] - 1;
      end
    end
  end

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < NREG; i++)
      mem_rdata[i*DATA_W +: DATA_W] = (pend_cnt[i] == 1) ? pend_data[i] : ~pend_data[i];
  end

  typedef struct { logic err; logic [DATA_W-1:0] data; } exp_t;
  exp_t              cpu_q[$];
  logic [DBG_W-1:0]  dbg_q[$];
  logic [DATA_W-1:0] cpu_held = '0;
  logic [DBG_W-1:0]  dbg_held = '0;
  logic [DATA_W-1:0] ref_cpu_rdata = '0;
  int unsigned       cpu_done = 0;
  bit                bus_resp_now = 1'b0;
  int                tests = 0;
  int                fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every response pulse, otherwise checks held data
  always @(negedge clk) begin
    if (rst) begin
      check("mem_en_onehot", 64'($onehot0(mem_en) && (!mem_we || mem_en != '0)), 64'(1));
      if (cpu_ready) begin
        if (cpu_q.size() == 0) begin
          check("cpu_ready_unexpected", 64'(cpu_ready), 64'(0));
        end else begin
          exp_t e;
          e = cpu_q.pop_front();
          check("cpu_err", 64'(cpu_err), 64'(e.err));
          check("cpu_rdata", 64'(cpu_rdata), 64'(e.data));
          cpu_held = e.data;
        end
      end else begin
        check("cpu_rdata_held", 64'(cpu_rdata), 64'(cpu_held));
        check("cpu_err_idle", 64'(cpu_err), 64'(0));
      end
      if (dbg_valid) begin
        if (dbg_q.size() == 0) begin
          check("dbg_valid_unexpected", 64'(dbg_valid), 64'(0));
        end else begin
          logic [DBG_W-1:0] d;
          d = dbg_q.pop_front();
          check("dbg_rdata", 64'(dbg_rdata), 64'(d));
          dbg_held = d;
        end
      end else begin
        check("dbg_rdata_held", 64'(dbg_rdata), 64'(dbg_held));
      end
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      bus_resp_now = 1'b0;
    end
  endtask

  task automatic cpu_xact(input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd, input bit chk);
    exp_t            e;
    int unsigned     reg_i, idx, issue, lat;
    logic [NREG-1:0] exp_en;
    bit              done;
    reg_i  = 32'(a[ADDR_W-1 -: 2]);
    idx    = 32'(a[5:0]);
    exp_en = '0;
    e.err  = 1'b0;
    e.data = ref_cpu_rdata;
    lat    = 1;
    if (reg_i >= NREG) begin
      e.err = 1'b1;
      if (!we) e.data = '0;
    end else if (we && RO[reg_i]) begin
      e.err = 1'b1;
    end else if (we) begin
      ref_mem[reg_i][idx] = wd;
      exp_en[reg_i] = 1'b1;
    end else begin
      e.data = ref_mem[reg_i][idx];
      exp_en[reg_i] = 1'b1;
      lat = READ_LAT + 1;
    end
    ref_cpu_rdata = e.data;
    cpu_q.push_back(e);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    issue = cyc + (bus_resp_now ? 1 : 0);
    if (chk && !bus_resp_now) begin
      #1;
      check("cpu_grant_mem_en", 64'(mem_en), 64'(exp_en));
      check("cpu_grant_mem_we", 64'(mem_we), 64'(we && exp_en != '0));
    end
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(posedge clk);
      #1;
      done = cpu_ready;
    end
    if (!done) check("cpu_timeout", 64'(0), 64'(1));
    else if (chk) check("cpu_latency", 64'(cyc - issue), 64'(lat));
    cpu_req = 1'b0;
    bus_resp_now = 1'b1;
    cpu_done++;
  endtask

`ifdef DBG_PORT_EN
  task automatic dbg_xact(input logic [ADDR_W-1:0] a, input bit chk, output int unsigned seen);
    int unsigned      reg_i, idx, issue, lat, start;
    logic [NREG-1:0]  exp_en;
    logic [DBG_W-1:0] d;
    bit               done;
    reg_i  = 32'(a[ADDR_W-1 -: 2]);
    idx    = 32'(a[5:0]);
    exp_en = '0;
    d      = '0;
    lat    = 1;
    if (reg_i < NREG) begin
      d = ref_mem[reg_i][idx][DBG_W-1:0];
      exp_en[reg_i] = 1'b1;
      lat = READ_LAT + 1;
    end
    dbg_q.push_back(d);
    start = cpu_done;
    dbg_req = 1'b1; dbg_addr = a;
    issue = cyc + (bus_resp_now ? 1 : 0);
    if (chk && !bus_resp_now) begin
      #1;
      check("dbg_grant_mem_en", 64'(mem_en), 64'(exp_en));
      check("dbg_grant_mem_we", 64'(mem_we), 64'(0));
    end
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(posedge clk);
      #1;
      done = dbg_valid;
    end
    if (!done) check("dbg_timeout", 64'(0), 64'(1));
    else if (chk) check("dbg_latency", 64'(cyc - issue), 64'(lat));
    seen = cpu_done - start;
    dbg_req = 1'b0;
    bus_resp_now = 1'b1;
  endtask
`endif

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_cpu_ready", 64'(cpu_ready), 64'(0));
    check("rst_cpu_err", 64'(cpu_err), 64'(0));
    check("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
    check("rst_dbg_valid", 64'(dbg_valid), 64'(0));
    check("rst_dbg_rdata", 64'(dbg_rdata), 64'(0));
    check("rst_mem_en", 64'(mem_en), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    cpu_q.delete();
    dbg_q.delete();
    cpu_held = '0; dbg_held = '0; ref_cpu_rdata = '0;
    cpu_req = 1'b0; dbg_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    bus_resp_now = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion before 500000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NREG; i++) begin
      pend_cnt[i] = 0;
      pend_data[i] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        ref_mem[i][j] = $urandom;
        dev_mem[i][j] = ref_mem[i][j];
      end
    end
    ref_mem[1][5] = 32'h1234_5678;
    dev_mem[1][5] = 32'h1234_5678;

    #2;
    do_reset();
    idle(2);

    // Directed: RAM write, ROM read, protected write, unmapped read, read-back
    cpu_xact(1'b1, {2'd0, 18'h00010}, 32'hDEAD_BEEF, 1'b1);
    idle(1);
    cpu_xact(1'b0, {2'd1, 18'h00005}, '0, 1'b1);
    idle(3);
    cpu_xact(1'b1, {2'd1, 18'h00005}, 32'hCAFE_F00D, 1'b1);
    cpu_xact(1'b0, {2'd3, 18'h00005}, '0, 1'b1);
    idle(1);
    cpu_xact(1'b0, {2'd0, 18'h00010}, '0, 1'b1);
    cpu_xact(1'b1, {2'd2, 18'h00003}, 32'h0BAD_F00D, 1'b1);
    cpu_xact(1'b1, {2'd3, 18'h00003}, 32'h1111_2222, 1'b1);
    cpu_xact(1'b0, {2'd2, 18'h00003}, '0, 1'b1);
    idle(2);

    // Back-to-back CPU reads with a debug reader held on the bus
`ifdef DBG_PORT_EN
    begin
      int unsigned seen;
      fork
        begin
          for (int k = 0; k < 12; k++)
            cpu_xact(1'b0, {2'($urandom_range(0, 2)), 12'd0, 6'($urandom_range(0, 63))}, '0, 1'b0);
        end
        begin
          dbg_xact({2'd0, 18'h00010}, 1'b0, seen);
          check("dbg_starve_bound", 64'(seen), 64'(DBG_MAX_WAIT));
        end
      join
    end
    idle(2);
    begin
      int unsigned seen;
      dbg_xact({2'd1, 18'h00005}, 1'b1, seen);
      idle(1);
      dbg_xact({2'd3, 18'h00005}, 1'b1, seen);
      idle(1);
    end
`else
    dbg_req = 1'b1;
    dbg_addr = {2'd0, 18'h00010};
    for (int k = 0; k < 12; k++)
      cpu_xact(1'b0, {2'($urandom_range(0, 2)), 12'd0, 6'($urandom_range(0, 63))}, '0, 1'b1);
    idle(4);
    dbg_req = 1'b0;
    idle(1);
`endif

    // Reset while a read sits in RD_WAIT
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = {2'd0, 18'h00010};
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    idle(8);
    cpu_xact(1'b0, {2'd0, 18'h00010}, '0, 1'b1);
    idle(1);

    // Randomized mix of accesses with random gaps
    for (int k = 0; k < 80; k++) begin
      logic [ADDR_W-1:0] a;
      a = {2'($urandom_range(0, 3)), 12'd0, 6'($urandom_range(0, 63))};
`ifdef DBG_PORT_EN
      if ($urandom_range(0, 3) == 0) begin
        int unsigned seen;
        dbg_xact(a, 1'b1, seen);
      end else
`endif
      cpu_xact(1'($urandom_range(0, 1)), a, $urandom, 1'b1);
      idle($urandom_range(0, 2));
    end

    idle(5);
    check("cpu_q_drained", 64'(cpu_q.size()), 64'(0));
    check("dbg_q_drained", 64'(dbg_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
